// File: rtl/flood_controller_if.sv
// Board RAM bus between the flood controller and a synchronous-read cell memory.
// The controller presents a cell address; read data returns one cycle later.
// A write stores MEM_WR_DATA at the same address while MEM_WR_EN is high.
interface flood_controller_if;
    logic [4:0] MEM_ROW;
    logic [4:0] MEM_COL;
    logic [2:0] MEM_RD_DATA;
    logic       MEM_WR_EN;
    logic [2:0] MEM_WR_DATA;

    modport master (
        output MEM_ROW,
        output MEM_COL,
        output MEM_WR_EN,
        output MEM_WR_DATA,
        input  MEM_RD_DATA
    );

    modport slave (
        input  MEM_ROW,
        input  MEM_COL,
        input  MEM_WR_EN,
        input  MEM_WR_DATA,
        output MEM_RD_DATA
    );
endinterface

// File: rtl/flood_controller.sv
// Flood-it game controller.
// A private bitmap records which cells already belong to the flood region
// that grows from (0,0).  Each accepted move recolours the region by raster
// scanning the board RAM.  Flooded cells of the wrong colour are rewritten.
// Unflooded cells of the new colour that touch the region join it.
// Passes repeat until a pass adds no cell; then the win/loss verdict is taken.
module flood_controller #(
    parameter int MAX_DIM = 26,
    parameter int CNT_W   = 10
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic                START,
    input  logic [4:0]          SIZE,
    input  logic [3:0]          COLOR_NUM,
    input  logic [7:0]          MAX_TRIES,
    input  logic                COLOR_SEL_SIG,
    input  logic [2:0]          COLOR_SELECTED,
    flood_controller_if.master  mem,
    output logic                BUSY,
    output logic                READY,
    output logic [2:0]          CUR_COLOR,
    output logic [7:0]          TRIES,
    output logic                WON,
    output logic                LOST
);

    localparam int NCELL = MAX_DIM * MAX_DIM;
    localparam int IDX_W = $clog2(NCELL);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT_RD  = 3'd1,
        S_INIT_LAT = 3'd2,
        S_SCAN_RD  = 3'd3,
        S_SCAN_EV  = 3'd4,
        S_CHECK    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [NCELL-1:0]   r_bitmap;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_changed;
    logic [4:0]         r_row;
    logic [4:0]         r_col;
    logic [4:0]         r_size;
    logic [3:0]         r_color_num;
    logic [7:0]         r_max_tries;
    logic [2:0]         r_cur_color;
    logic [7:0]         r_tries;
    logic               r_won;
    logic               r_lost;
    logic               r_ready;
    logic               r_busy;

    logic [IDX_W-1:0]   w_idx;
    logic               w_self;
    logic               w_up;
    logic               w_down;
    logic               w_left;
    logic               w_right;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_last_cell;
    logic               w_grow;
    logic               w_wr_en;
    logic               w_accept;
    logic [9:0]         w_area;
    logic               w_won_now;

    // Saturating move counter increment; the counter never wraps past 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = val + 8'd1;
        end
    endfunction

    // Cell index and bitmap view of the current scan cell and its neighbours.
    always_comb begin
        w_idx      = IDX_W'(r_row) * IDX_W'(MAX_DIM) + IDX_W'(r_col);
        w_self     = r_bitmap[w_idx];
        w_last_col = (r_col == (r_size - 5'd1));
        w_last_row = (r_row == (r_size - 5'd1));
        w_last_cell = w_last_col && w_last_row;
        if (r_row != 5'd0) begin
            w_up = r_bitmap[w_idx - IDX_W'(MAX_DIM)];
        end else begin
            w_up = 1'b0;
        end
        if (!w_last_row) begin
            w_down = r_bitmap[w_idx + IDX_W'(MAX_DIM)];
        end else begin
            w_down = 1'b0;
        end
        if (r_col != 5'd0) begin
            w_left = r_bitmap[w_idx - IDX_W'(1)];
        end else begin
            w_left = 1'b0;
        end
        if (!w_last_col) begin
            w_right = r_bitmap[w_idx + IDX_W'(1)];
        end else begin
            w_right = 1'b0;
        end
    end

    // Scan-cell decisions, move acceptance and the end-of-move verdict.
    always_comb begin
        w_grow  = (r_state == S_SCAN_EV) && !w_self &&
                  (mem.MEM_RD_DATA == r_cur_color) &&
                  (w_up || w_down || w_left || w_right);
        // The write is suppressed by START so that an abandoned scan never
        // touches the board again.
        w_wr_en = (r_state == S_SCAN_EV) && !START && w_self &&
                  (mem.MEM_RD_DATA != r_cur_color);
        w_accept = (r_state == S_IDLE) && COLOR_SEL_SIG && r_ready &&
                   !r_won && !r_lost &&
                   ({1'b0, COLOR_SELECTED} < r_color_num) &&
                   (COLOR_SELECTED != r_cur_color);
        w_area    = 10'(r_size) * 10'(r_size);
        w_won_now = (r_cnt == CNT_W'(w_area));
    end

    // Next-state logic; START overrides every state.
    always_comb begin
        w_state_next = r_state;
        if (START) begin
            w_state_next = S_INIT_RD;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_next = S_SCAN_RD;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_INIT_RD:  w_state_next = S_INIT_LAT;
                S_INIT_LAT: w_state_next = S_IDLE;
                S_SCAN_RD:  w_state_next = S_SCAN_EV;
                S_SCAN_EV: begin
                    if (!w_last_cell) begin
                        w_state_next = S_SCAN_RD;
                    end else if (r_changed || w_grow) begin
                        w_state_next = S_SCAN_RD;
                    end else begin
                        w_state_next = S_CHECK;
                    end
                end
                S_CHECK:    w_state_next = S_IDLE;
                default:    w_state_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // BUSY is registered from the next state so it equals (state != IDLE).
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
        end
    end

    // Game datapath: init, move acceptance, region growth, scan walk, verdict.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bitmap    <= '0;
            r_cnt       <= '0;
            r_changed   <= 1'b0;
            r_row       <= 5'd0;
            r_col       <= 5'd0;
            r_size      <= 5'd0;
            r_color_num <= 4'd0;
            r_max_tries <= 8'd0;
            r_cur_color <= 3'd0;
            r_tries     <= 8'd0;
            r_won       <= 1'b0;
            r_lost      <= 1'b0;
            r_ready     <= 1'b0;
        end else if (START) begin
            r_bitmap    <= {{(NCELL-1){1'b0}}, 1'b1};
            r_cnt       <= CNT_W'(1);
            r_changed   <= 1'b0;
            r_row       <= 5'd0;
            r_col       <= 5'd0;
            r_size      <= SIZE;
            r_color_num <= COLOR_NUM;
            r_max_tries <= MAX_TRIES;
            r_tries     <= 8'd0;
            r_won       <= 1'b0;
            r_lost      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tries     <= sat_inc8(r_tries);
                        r_cur_color <= COLOR_SELECTED;
                        r_row       <= 5'd0;
                        r_col       <= 5'd0;
                        r_changed   <= 1'b0;
                    end
                end
                S_INIT_LAT: begin
                    r_cur_color <= mem.MEM_RD_DATA;
                    r_ready     <= 1'b1;
                end
                S_SCAN_EV: begin
                    if (w_grow) begin
                        r_bitmap[w_idx] <= 1'b1;
                        r_cnt           <= r_cnt + CNT_W'(1);
                        r_changed       <= 1'b1;
                    end
                    // After the last cell the address either restarts a new
                    // pass or stays put on the final cell.
                    if (w_last_cell) begin
                        if (r_changed || w_grow) begin
                            r_row     <= 5'd0;
                            r_col     <= 5'd0;
                            r_changed <= 1'b0;
                        end
                    end else if (w_last_col) begin
                        r_col <= 5'd0;
                        r_row <= r_row + 5'd1;
                    end else begin
                        r_col <= r_col + 5'd1;
                    end
                end
                S_CHECK: begin
                    r_won  <= w_won_now;
                    r_lost <= !w_won_now && (r_tries == r_max_tries);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.MEM_ROW     = r_row;
    assign mem.MEM_COL     = r_col;
    assign mem.MEM_WR_EN   = w_wr_en;
    assign mem.MEM_WR_DATA = r_cur_color;

    assign BUSY      = r_busy;
    assign READY     = r_ready;
    assign CUR_COLOR = r_cur_color;
    assign TRIES     = r_tries;
    assign WON       = r_won;
    assign LOST      = r_lost;

endmodule

// File: tb/tb_flood_controller.sv
// Directed bench for flood_controller with a synchronous-read board RAM model.
module tb_flood_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] size;
    logic [3:0] cnum;
    logic [7:0] mtries;
    logic       sel;
    logic [2:0] selc;
    logic       busy;
    logic       ready;
    logic       won;
    logic       lost;
    logic [2:0] cur;
    logic [7:0] tries;

    logic [2:0] ram   [0:25][0:25];
    logic [2:0] board [0:25][0:25];
    logic [2:0] expb  [0:25][0:25];
    logic       load;
    int         wr_cnt = 0;

    int checks = 0;
    int errors = 0;
    int n;
    int w0;

    flood_controller_if mif();

    flood_controller #(.MAX_DIM(26), .CNT_W(10)) dut (
        .CLOCK          (clk),
        .RESET_N        (rst_n),
        .START          (start),
        .SIZE           (size),
        .COLOR_NUM      (cnum),
        .MAX_TRIES      (mtries),
        .COLOR_SEL_SIG  (sel),
        .COLOR_SELECTED (selc),
        .mem            (mif),
        .BUSY           (busy),
        .READY          (ready),
        .CUR_COLOR      (cur),
        .TRIES          (tries),
        .WON            (won),
        .LOST           (lost)
    );

    always #5 clk = ~clk;

    // Board RAM: bulk load from the stimulus board, writes from the DUT.
    always @(posedge clk) begin
        if (load) begin
            ram <= board;
        end else if (mif.MEM_WR_EN) begin
            ram[mif.MEM_ROW][mif.MEM_COL] <= mif.MEM_WR_DATA;
            wr_cnt <= wr_cnt + 1;
        end
        mif.MEM_RD_DATA <= ram[mif.MEM_ROW][mif.MEM_COL];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [2:0] v);
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++) begin
                board[r][c] = v;
                expb[r][c]  = v;
            end
    endtask

    task automatic load_board();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic check_board(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                if (ram[r][c] !== expb[r][c]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic do_start(input logic [4:0] s, input logic [3:0] c, input logic [7:0] m);
        int k;
        @(negedge clk);
        start = 1'b1; size = s; cnum = c; mtries = m;
        @(negedge clk);
        start = 1'b0; size = 5'd0; cnum = 4'd0; mtries = 8'd0;
        k = 0;
        while (ready !== 1'b1 && k < 10) begin
            k++;
            @(negedge clk);
        end
        check("ready_after_start", ready, 1);
    endtask

    task automatic pulse_sel(input logic [2:0] c);
        @(negedge clk);
        sel = 1'b1; selc = c;
        @(negedge clk);
        sel = 1'b0; selc = 3'd0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 6000) begin
            cyc++;
            @(negedge clk);
        end
        check("idle_within_budget", (cyc < 6000), 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; selc = 3'd0; load = 1'b0;
        size = 5'd0; cnum = 4'd0; mtries = 8'd0;
        fill(3'd7);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_won", won, 0);
        check("rst_lost", lost, 0);
        check("rst_tries", tries, 0);
        check("rst_cur", cur, 0);
        check("rst_row", mif.MEM_ROW, 0);
        check("rst_col", mif.MEM_COL, 0);
        check("rst_wren", mif.MEM_WR_EN, 0);
        check("rst_wrdata", mif.MEM_WR_DATA, 0);
        @(negedge clk) rst_n = 1'b1;

        // Selection before any START is ignored.
        pulse_sel(3'd1);
        wait_idle(n);
        check("nostart_busy_cycles", n, 0);
        check("nostart_tries", tries, 0);

        // 2x2 board {0,1;1,1}, choose 1: one write, two passes, win.
        fill(3'd7);
        board[0][0] = 3'd0; board[0][1] = 3'd1; board[1][0] = 3'd1; board[1][1] = 3'd1;
        expb[0][0] = 3'd1; expb[0][1] = 3'd1; expb[1][0] = 3'd1; expb[1][1] = 3'd1;
        load_board();
        do_start(5'd2, 4'd4, 8'd10);
        check("b2_init_cur", cur, 0);
        w0 = wr_cnt;
        pulse_sel(3'd1);
        wait_idle(n);
        check("b2_busy_cycles", n, 17);
        check("b2_writes", wr_cnt - w0, 1);
        check_board("b2_board");
        check("b2_won", won, 1);
        check("b2_lost", lost, 0);
        check("b2_tries", tries, 1);
        check("b2_cur", cur, 1);

        // 3x3 checkerboard, COLOR_NUM=2, MAX_TRIES=1.
        fill(3'd7);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                board[r][c] = 3'((r + c) % 2);
                expb[r][c]  = 3'((r + c) % 2);
            end
        load_board();
        do_start(5'd3, 4'd2, 8'd1);
        check("cb_init_cur", cur, 0);
        w0 = wr_cnt;
        pulse_sel(3'd0);
        wait_idle(n);
        check("same_color_busy", n, 0);
        pulse_sel(3'd2);
        wait_idle(n);
        check("out_of_range_busy", n, 0);
        check("ignored_tries", tries, 0);
        check("ignored_writes", wr_cnt - w0, 0);
        pulse_sel(3'd1);
        wait_idle(n);
        expb[0][0] = 3'd1;
        check("cb_busy_cycles", n, 37);
        check("cb_writes", wr_cnt - w0, 1);
        check_board("cb_board");
        check("cb_counter", dut.r_cnt, 3);
        check("cb_won", won, 0);
        check("cb_lost", lost, 1);
        pulse_sel(3'd0);
        wait_idle(n);
        check("after_lost_busy", n, 0);
        check("after_lost_tries", tries, 1);

        // Selection pulsed while busy is dropped; then a winning second move.
        fill(3'd7);
        board[0][0] = 3'd0; board[0][1] = 3'd1; board[0][2] = 3'd2;
        board[1][0] = 3'd1; board[1][1] = 3'd1; board[1][2] = 3'd2;
        board[2][0] = 3'd2; board[2][1] = 3'd2; board[2][2] = 3'd2;
        expb = board;
        load_board();
        do_start(5'd3, 4'd3, 8'd5);
        w0 = wr_cnt;
        pulse_sel(3'd1);
        repeat (5) @(negedge clk);
        sel = 1'b1; selc = 3'd2;
        @(negedge clk);
        sel = 1'b0; selc = 3'd0;
        wait_idle(n);
        expb[0][0] = 3'd1;
        check("busy_sel_tries", tries, 1);
        check("busy_sel_writes", wr_cnt - w0, 1);
        check("busy_sel_cur", cur, 1);
        check_board("busy_sel_board");
        check("busy_sel_won", won, 0);
        w0 = wr_cnt;
        pulse_sel(3'd2);
        wait_idle(n);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                expb[r][c] = 3'd2;
        check("move2_tries", tries, 2);
        check("move2_writes", wr_cnt - w0, 4);
        check_board("move2_board");
        check("move2_won", won, 1);

        // Full 26x26 board: all 2 except (0,0)=0.
        fill(3'd2);
        board[0][0] = 3'd0;
        load_board();
        do_start(5'd26, 4'd3, 8'd10);
        w0 = wr_cnt;
        pulse_sel(3'd2);
        wait_idle(n);
        check("big_busy_cycles", n, 2705);
        check("big_won", won, 1);
        check("big_writes", wr_cnt - w0, 1);
        check_board("big_board");

        // START in the middle of a scan abandons it.
        fill(3'd2);
        board[0][0] = 3'd0;
        load_board();
        do_start(5'd26, 4'd3, 8'd10);
        pulse_sel(3'd2);
        repeat (50) @(negedge clk);
        w0 = wr_cnt;
        do_start(5'd26, 4'd3, 8'd10);
        check("restart_tries", tries, 0);
        check("restart_busy", busy, 0);
        check("restart_won", won, 0);
        check("restart_cur", cur, 2);
        check("restart_writes", wr_cnt - w0, 0);

        // Reset in the middle of a scan aborts at once.
        pulse_sel(3'd0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 0);
        check("midrst_tries", tries, 0);
        check("midrst_cur", cur, 0);
        check("midrst_row", mif.MEM_ROW, 0);
        check("midrst_col", mif.MEM_COL, 0);
        check("midrst_wren", mif.MEM_WR_EN, 0);
        check("midrst_won", won, 0);
        check("midrst_lost", lost, 0);
        w0 = wr_cnt;
        repeat (5) @(negedge clk);
        check("midrst_no_writes", wr_cnt - w0, 0);
        rst_n = 1'b1;
        pulse_sel(3'd1);
        wait_idle(n);
        check("postrst_sel_busy", n, 0);
        check("postrst_tries", tries, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
